// File: rtl/ewrapper_link_txo_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ewrapper_link_txo_framer_pkg
// Purpose  : Shared definitions for the eLink transmit framer. Holds the FSM
//            state encoding, the idle-lane constant, the packet byte-lane
//            layout and the held-transaction record.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package ewrapper_link_txo_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    localparam int LANE_W     = 8;
    localparam int NUM_LANES  = 9;
    localparam int BEAT_W     = LANE_W * NUM_LANES;
    localparam int FRAME_LANE = 8;

    // Frame-lane value (and every other lane) during idle and gap beats.
    localparam logic [LANE_W-1:0] FRAME_IDLE = 8'h00;
    localparam logic [BEAT_W-1:0] IDLE_WORD  = {NUM_LANES{FRAME_IDLE}};

    // Beat0 layout: header, 4 destination-address lanes, 3 data lanes.
    localparam int B0_HDR  = 0;
    localparam int B0_DST  = 1;
    localparam int B0_DATA = 5;
    // Beat1 layout: low data byte, 4 source-address lanes, 3 pad lanes.
    localparam int B1_DATA = 0;
    localparam int B1_SRC  = 1;
    localparam int B1_PAD  = 5;

    typedef struct packed {
        logic        write;
        logic [1:0]  datamode;
        logic [3:0]  ctrlmode;
        logic [31:0] dstaddr;
        logic [31:0] srcaddr;
        logic [31:0] data;
    } txn_t;

    function automatic logic [LANE_W-1:0] hdr_byte(input txn_t t);
        return {t.ctrlmode, t.datamode, t.write, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ewrapper_txo_pack.sv
`default_nettype none
// ============================================================================
// Module   : ewrapper_txo_pack
// Purpose  : Combinational mapping of a held eMesh transaction onto the two
//            72-bit beats of a link packet (lane i = bits [8i+7:8i]).
// Ports    : txn_i   - held transaction
//            beat0_o - first beat (header, dstaddr, data[31:8], frame)
//            beat1_o - second beat (data[7:0], srcaddr, pad, frame)
// Revision : 1.0  initial release
// ============================================================================
module ewrapper_txo_pack
    import ewrapper_link_txo_framer_pkg::*;
#(
    parameter logic [7:0] FRAME_BYTE = 8'hFF
) (
    input  txn_t               txn_i,
    output logic [BEAT_W-1:0]  beat0_o,
    output logic [BEAT_W-1:0]  beat1_o
);

    always_comb begin
        beat0_o = IDLE_WORD;
        beat1_o = IDLE_WORD;

        beat0_o[B0_HDR*LANE_W +: LANE_W] = hdr_byte(txn_i);
        // Address and data go out most-significant byte first.
        for (int i = 0; i < 4; i++) begin
            beat0_o[(B0_DST+i)*LANE_W +: LANE_W] = txn_i.dstaddr[31-8*i -: 8];
        end
        for (int i = 0; i < 3; i++) begin
            beat0_o[(B0_DATA+i)*LANE_W +: LANE_W] = txn_i.data[31-8*i -: 8];
        end
        beat0_o[FRAME_LANE*LANE_W +: LANE_W] = FRAME_BYTE;

        beat1_o[B1_DATA*LANE_W +: LANE_W] = txn_i.data[7:0];
        for (int i = 0; i < 4; i++) begin
            beat1_o[(B1_SRC+i)*LANE_W +: LANE_W] = txn_i.srcaddr[31-8*i -: 8];
        end
        for (int i = 0; i < 3; i++) begin
            beat1_o[(B1_PAD+i)*LANE_W +: LANE_W] = FRAME_IDLE;
        end
        beat1_o[FRAME_LANE*LANE_W +: LANE_W] = FRAME_BYTE;
    end

endmodule
`default_nettype wire

// File: rtl/ewrapper_link_txo_framer.sv
`default_nettype none
// ============================================================================
// Module   : ewrapper_link_txo_framer
// Purpose  : Transmit packet framer in the serializer CLK_DIV domain. Accepts
//            one transaction at a time (access/wait), emits it as two 72-bit
//            beats, optionally followed by IDLE_GAP forced idle beats.
// Ports    : CLK_IN, RESET_N (async, active low)
//            ACCESS_IN/WRITE_IN/DATAMODE_IN/CTRLMODE_IN/DSTADDR_IN/
//            SRCADDR_IN/DATA_IN - upstream transaction
//            WAIT_OUT       - holding register occupied (registered)
//            TX_WAIT_IN     - remote receiver throttle
//            DATA_OUT_TO_IO - registered 72-bit parallel word to serializer
//            TX_BUSY_OUT    - packet or idle gap in progress
// Macro    : ELINK_TXO_WAIT_SYNC_EN - double-flop synchronize TX_WAIT_IN
// Revision : 1.0  initial release
// ============================================================================
module ewrapper_link_txo_framer
    import ewrapper_link_txo_framer_pkg::*;
#(
    parameter int unsigned IDLE_GAP   = 0,
    parameter logic [7:0]  FRAME_BYTE = 8'hFF
) (
    input  logic               CLK_IN,
    input  logic               RESET_N,
    input  logic               ACCESS_IN,
    input  logic               WRITE_IN,
    input  logic [1:0]         DATAMODE_IN,
    input  logic [3:0]         CTRLMODE_IN,
    input  logic [31:0]        DSTADDR_IN,
    input  logic [31:0]        SRCADDR_IN,
    input  logic [31:0]        DATA_IN,
    output logic               WAIT_OUT,
    input  logic               TX_WAIT_IN,
    output logic [BEAT_W-1:0]  DATA_OUT_TO_IO,
    output logic               TX_BUSY_OUT
);

    localparam bit         HAS_GAP  = (IDLE_GAP != 0);
    localparam logic [2:0] GAP_INIT = HAS_GAP ? 3'(IDLE_GAP - 1) : 3'd0;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   out_q, out_d;
    logic                busy_q, busy_d;
    logic [2:0]          gap_q, gap_d;
    logic                hold_valid_q, hold_valid_d;
    txn_t                hold_q, hold_d;

    logic                wait_eff;
    logic                can_start;
    logic                take;
    logic [BEAT_W-1:0]   beat0, beat1;

`ifdef ELINK_TXO_WAIT_SYNC_EN
    logic [1:0] wait_sync_q;

    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            wait_sync_q <= 2'b00;
        end else begin
            wait_sync_q <= {wait_sync_q[0], TX_WAIT_IN};
        end
    end

    assign wait_eff = wait_sync_q[1];
`else
    assign wait_eff = TX_WAIT_IN;
`endif

    ewrapper_txo_pack #(
        .FRAME_BYTE (FRAME_BYTE)
    ) u_pack (
        .txn_i   (hold_q),
        .beat0_o (beat0),
        .beat1_o (beat1)
    );

    // Holding register. Capture and release are mutually exclusive: capture
    // needs an empty register, release needs a full one.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        if (ACCESS_IN && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_d       = '{write:    WRITE_IN,
                             datamode: DATAMODE_IN,
                             ctrlmode: CTRLMODE_IN,
                             dstaddr:  DSTADDR_IN,
                             srcaddr:  SRCADDR_IN,
                             data:     DATA_IN};
        end else if (take) begin
            hold_valid_d = 1'b0;
        end
    end

    // Framer FSM. Remote wait is only consulted where a new packet could
    // start, so a packet is never split once beat0 has gone out.
    always_comb begin
        state_d   = state_q;
        out_d     = IDLE_WORD;
        busy_d    = 1'b0;
        gap_d     = gap_q;
        can_start = 1'b0;
        take      = 1'b0;

        case (state_q)
            ST_BEAT0: begin
                state_d = ST_BEAT1;
                out_d   = beat1;
                busy_d  = 1'b1;
            end
            ST_BEAT1: begin
                if (HAS_GAP) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_INIT;
                    busy_d  = 1'b1;
                end else begin
                    can_start = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q != 3'd0) begin
                    gap_d  = gap_q - 3'd1;
                    busy_d = 1'b1;
                end else begin
                    can_start = 1'b1;
                end
            end
            default: begin
                can_start = 1'b1;
            end
        endcase

        if (can_start) begin
            if (hold_valid_q && !wait_eff) begin
                state_d = ST_BEAT0;
                out_d   = beat0;
                busy_d  = 1'b1;
                take    = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            out_q        <= IDLE_WORD;
            busy_q       <= 1'b0;
            gap_q        <= 3'd0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            busy_q       <= busy_d;
            gap_q        <= gap_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end

    assign WAIT_OUT       = hold_valid_q;
    assign DATA_OUT_TO_IO = out_q;
    assign TX_BUSY_OUT    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ewrapper_link_txo_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ewrapper_link_txo_framer
// Purpose  : Scoreboard bench for ewrapper_link_txo_framer. Instance A uses
//            IDLE_GAP=0, instance B uses IDLE_GAP=2. Expected beats (with
//            the cycle they must appear on) are queued by the stimulus and
//            popped by per-instance monitors whenever a frame lane is live.
// Macro    : ELINK_TXO_WAIT_SYNC_EN - adjusts expected remote-wait latency
// Revision : 1.0  initial release
// ============================================================================
module tb_ewrapper_link_txo_framer;

`ifdef ELINK_TXO_WAIT_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    typedef struct packed {
        logic [3:0]  cm;
        logic [1:0]  dm;
        logic        wr;
        logic [31:0] dst;
        logic [31:0] src;
        logic [31:0] data;
    } tb_txn_t;

    typedef struct {
        logic [71:0] beat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        access_a, access_b;
    logic        wr;
    logic [1:0]  dm;
    logic [3:0]  cm;
    logic [31:0] dst, src, data;
    logic        txwait_a, txwait_b;
    logic        wait_a, wait_b, busy_a, busy_b;
    logic [71:0] out_a, out_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ewrapper_link_txo_framer #(.IDLE_GAP(0), .FRAME_BYTE(8'hFF)) u_dut_a (
        .CLK_IN(clk), .RESET_N(rst_n), .ACCESS_IN(access_a), .WRITE_IN(wr),
        .DATAMODE_IN(dm), .CTRLMODE_IN(cm), .DSTADDR_IN(dst), .SRCADDR_IN(src),
        .DATA_IN(data), .WAIT_OUT(wait_a), .TX_WAIT_IN(txwait_a),
        .DATA_OUT_TO_IO(out_a), .TX_BUSY_OUT(busy_a));

    ewrapper_link_txo_framer #(.IDLE_GAP(2), .FRAME_BYTE(8'hFF)) u_dut_b (
        .CLK_IN(clk), .RESET_N(rst_n), .ACCESS_IN(access_b), .WRITE_IN(wr),
        .DATAMODE_IN(dm), .CTRLMODE_IN(cm), .DSTADDR_IN(dst), .SRCADDR_IN(src),
        .DATA_IN(data), .WAIT_OUT(wait_b), .TX_WAIT_IN(txwait_b),
        .DATA_OUT_TO_IO(out_b), .TX_BUSY_OUT(busy_b));

    function automatic logic [71:0] mk0(input tb_txn_t t);
        return {8'hFF, t.data[15:8], t.data[23:16], t.data[31:24],
                t.dst[7:0], t.dst[15:8], t.dst[23:16], t.dst[31:24],
                t.cm, t.dm, t.wr, 1'b0};
    endfunction

    function automatic logic [71:0] mk1(input tb_txn_t t);
        return {8'hFF, 24'h0, t.src[7:0], t.src[15:8], t.src[23:16],
                t.src[31:24], t.data[7:0]};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Wait for the first falling edge at which at least n rising edges have occurred.
    task automatic at_neg(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic drive(input tb_txn_t t);
        wr = t.wr; dm = t.dm; cm = t.cm; dst = t.dst; src = t.src; data = t.data;
    endtask

    task automatic push_a(input tb_txn_t t, input int c0);
        exp_t e;
        e.beat = mk0(t); e.cyc = c0;     qa.push_back(e);
        e.beat = mk1(t); e.cyc = c0 + 1; qa.push_back(e);
    endtask

    task automatic push_b(input tb_txn_t t, input int c0);
        exp_t e;
        e.beat = mk0(t); e.cyc = c0;     qb.push_back(e);
        e.beat = mk1(t); e.cyc = c0 + 1; qb.push_back(e);
    endtask

    // Monitors: any live frame lane must match the head of the queue, on time.
    always @(negedge clk) begin
        exp_t e;
        if (out_a[71:64] != 8'h00) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_extra_beat: got %0h expected no beat (cycle %0d)", out_a, cyc);
            end else begin
                e = qa.pop_front();
                chk("a_beat", out_a, e.beat);
                chk("a_beat_cycle", 72'(cyc), 72'(e.cyc));
                chk("a_busy_in_packet", 72'(busy_a), 72'd1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (out_b[71:64] != 8'h00) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_extra_beat: got %0h expected no beat (cycle %0d)", out_b, cyc);
            end else begin
                e = qb.pop_front();
                chk("b_beat", out_b, e.beat);
                chk("b_beat_cycle", 72'(cyc), 72'(e.cyc));
                chk("b_busy_in_packet", 72'(busy_b), 72'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int      k, r;
        exp_t    e;
        tb_txn_t t1, tx[3], ta, tb2;

        rst_n = 1'b0; access_a = 1'b0; access_b = 1'b0;
        txwait_a = 1'b0; txwait_b = 1'b0;
        wr = 1'b0; dm = 2'b00; cm = 4'h0; dst = '0; src = '0; data = '0;

        #1;
        chk("rst_out_a",  out_a, 72'h0);
        chk("rst_wait_a", 72'(wait_a), 72'd0);
        chk("rst_busy_a", 72'(busy_a), 72'd0);
        chk("rst_out_b",  out_b, 72'h0);
        chk("rst_wait_b", 72'(wait_b), 72'd0);
        chk("rst_busy_b", 72'(busy_b), 72'd0);
        at_neg(2);
        rst_n = 1'b1;

        // Single write with hand-computed beats.
        t1 = '{cm: 4'h0, dm: 2'b10, wr: 1'b1, dst: 32'h8080_0010,
               src: 32'h0, data: 32'hA5A5_1234};
        at_neg(4);
        drive(t1); access_a = 1'b1;
        k = cyc + 1;
        e.beat = 72'hFF_12_A5_A5_10_00_80_80_0A; e.cyc = k + 1; qa.push_back(e);
        e.beat = 72'hFF_00_00_00_00_00_00_00_34; e.cyc = k + 2; qa.push_back(e);
        at_neg(k);
        chk("single_wait_after_accept", 72'(wait_a), 72'd1);
        access_a = 1'b0;
        at_neg(k + 1);
        chk("single_wait_freed", 72'(wait_a), 72'd0);
        at_neg(k + 3);
        chk("single_idle_out", out_a, 72'h0);
        chk("single_idle_busy", 72'(busy_a), 72'd0);

        // Back-to-back with ACCESS_IN held high.
        tx[0] = '{cm: 4'h3, dm: 2'b01, wr: 1'b1, dst: 32'h1234_5678, src: 32'hCAFE_F00D, data: 32'hDEAD_BEEF};
        tx[1] = '{cm: 4'hC, dm: 2'b11, wr: 1'b0, dst: 32'h0000_0004, src: 32'h8765_4321, data: 32'h0102_0304};
        tx[2] = '{cm: 4'hF, dm: 2'b00, wr: 1'b1, dst: 32'hFFFF_FFFF, src: 32'h1111_2222, data: 32'h5A5A_C3C3};
        at_neg(k + 5);
        drive(tx[0]); access_a = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 3; i++) push_a(tx[i], k + 2*i + 1);
        for (int i = 0; i < 3; i++) begin
            at_neg(k + 2*i);
            chk("b2b_wait_high", 72'(wait_a), 72'd1);
            if (i < 2) begin
                drive(tx[i+1]);
                at_neg(k + 2*i + 1);
                chk("b2b_wait_low", 72'(wait_a), 72'd0);
            end else begin
                access_a = 1'b0;
            end
        end
        at_neg(k + 7);
        chk("b2b_done_out", out_a, 72'h0);

        // Remote wait asserted while beat0 is on the wire.
        ta  = '{cm: 4'h5, dm: 2'b10, wr: 1'b1, dst: 32'hA000_0001, src: 32'h0, data: 32'h7777_8888};
        tb2 = '{cm: 4'h9, dm: 2'b01, wr: 1'b0, dst: 32'hB000_0002, src: 32'hC000_0003, data: 32'h0};
        at_neg(k + 10);
        drive(ta); access_a = 1'b1;
        k = cyc + 1;
        push_a(ta, k + 1);
        at_neg(k);
        chk("twait_wait_accept", 72'(wait_a), 72'd1);
        drive(tb2);
        if (SL != 0) txwait_a = 1'b1;
        at_neg(k + 1);
        if (SL == 0) txwait_a = 1'b1;
        at_neg(k + 2);
        chk("twait_second_held", 72'(wait_a), 72'd1);
        access_a = 1'b0;
        at_neg(k + 3);
        chk("twait_idle_out", out_a, 72'h0);
        chk("twait_idle_busy", 72'(busy_a), 72'd0);
        at_neg(k + 5);
        chk("twait_still_held", 72'(wait_a), 72'd1);
        txwait_a = 1'b0;
        r = k + 5;
        push_a(tb2, r + 1 + SL);
        at_neg(r + 3 + SL);
        chk("twait_release_out", out_a, 72'h0);
        chk("twait_release_wait", 72'(wait_a), 72'd0);

        // ACCESS_IN pulsed while WAIT_OUT=1 must be ignored.
        at_neg(r + 6 + SL);
        drive(tx[1]); access_a = 1'b1;
        k = cyc + 1;
        push_a(tx[1], k + 1);
        at_neg(k);
        drive(tx[2]);
        at_neg(k + 1);
        access_a = 1'b0;
        at_neg(k + 4);
        chk("ignored_out", out_a, 72'h0);
        chk("ignored_wait", 72'(wait_a), 72'd0);
        chk("ignored_busy", 72'(busy_a), 72'd0);

        // IDLE_GAP=2 on instance B with a second packet queued.
        at_neg(k + 6);
        drive(tx[0]); access_b = 1'b1;
        k = cyc + 1;
        push_b(tx[0], k + 1);
        push_b(tx[2], k + 5);
        at_neg(k);
        drive(tx[2]);
        at_neg(k + 2);
        chk("gap_second_held", 72'(wait_b), 72'd1);
        access_b = 1'b0;
        for (int g = 3; g <= 4; g++) begin
            at_neg(k + g);
            chk("gap_zero_beat", out_b, 72'h0);
            chk("gap_busy", 72'(busy_b), 72'd1);
        end
        at_neg(k + 7);
        chk("gap_after_busy", 72'(busy_b), 72'd1);
        at_neg(k + 9);
        chk("gap_end_busy", 72'(busy_b), 72'd0);
        chk("gap_end_out", out_b, 72'h0);

        // Reset pulsed during BEAT0.
        at_neg(k + 11);
        drive(t1); access_a = 1'b1;
        k = cyc + 1;
        e.beat = mk0(t1); e.cyc = k + 1; qa.push_back(e);
        at_neg(k);
        access_a = 1'b0;
        at_neg(k + 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_out", out_a, 72'h0);
        chk("rstmid_wait", 72'(wait_a), 72'd0);
        chk("rstmid_busy", 72'(busy_a), 72'd0);
        at_neg(k + 2);
        rst_n = 1'b1;
        at_neg(k + 3);
        chk("rstmid_no_beat1", out_a, 72'h0);
        at_neg(k + 5);
        chk("rstmid_quiet", out_a, 72'h0);

        chk("queue_a_drained", 72'(qa.size()), 72'd0);
        chk("queue_b_drained", 72'(qb.size()), 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
